// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle LEGv8 datapath: FETCH/DECODE/EXEC/MEM/WB with
// variable-latency memory handshakes, illegal-opcode and memory-timeout traps.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        branch,
  output logic        uncond_branch,
  output logic [3:0]  aluop,
  output logic [1:0]  signop,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI,
    C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR
  } cls_t;

  state_t           state_q, state_next;
  cls_t             cls_q, cls_dec;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cause_q, cause_next;
  logic             wait_low, timeout_hit;
  logic             f_reg2loc, f_alusrc, f_mem2reg;
  logic [3:0]       f_aluop;
  logic [1:0]       f_signop;

  assign state       = state_q;
  assign wait_low    = ((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready);
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_MAX);

  // Opcode classification; first matching pattern wins
  always_comb begin
    cls_dec = C_NONE;
    casez (opcode)
      11'b?0001010???: cls_dec = C_AND;
      11'b?0101010???: cls_dec = C_ORR;
      11'b?0?01011???: cls_dec = C_ADD;
      11'b?1?01011???: cls_dec = C_SUB;
      11'b?0?10001???: cls_dec = C_ADDI;
      11'b?1?10001???: cls_dec = C_SUBI;
      11'b110100101??: cls_dec = C_MOVZ;
      11'b?00101?????: cls_dec = C_B;
      11'b?011010????: cls_dec = C_CBZ;
      11'b??111000010: cls_dec = C_LDUR;
      11'b??111000000: cls_dec = C_STUR;
      default:         cls_dec = C_NONE;
    endcase
  end

  // Datapath fields implied by the latched instruction class
  always_comb begin
    f_reg2loc = 1'b0;
    f_alusrc  = 1'b0;
    f_mem2reg = 1'b0;
    f_aluop   = 4'b0000;
    f_signop  = 2'b00;
    case (cls_q)
      C_ORR:  f_aluop = 4'b0001;
      C_ADD:  f_aluop = 4'b0010;
      C_SUB:  f_aluop = 4'b0110;
      C_ADDI: begin f_aluop = 4'b0010; f_signop = 2'b01; f_alusrc = 1'b1; end
      C_SUBI: begin f_aluop = 4'b0110; f_signop = 2'b01; f_alusrc = 1'b1; end
      C_MOVZ: begin f_aluop = 4'b1000; f_signop = 2'b10; f_alusrc = 1'b1; end
      C_B:    f_signop = 2'b11;
      C_CBZ:  begin f_aluop = 4'b1001; f_signop = 2'b11; f_reg2loc = 1'b1; end
      C_LDUR: begin f_aluop = 4'b0010; f_alusrc = 1'b1; f_mem2reg = 1'b1; end
      C_STUR: begin f_aluop = 4'b0010; f_alusrc = 1'b1; f_reg2loc = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_next;
      cause_q <= cause_next;
      if (state_q == S_DECODE) cls_q <= cls_dec;
      if (state_next != state_q) cnt_q <= '0;
      else if (wait_low)         cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next state and control outputs; reset forces every output low
  always_comb begin
    state_next    = state_q;
    cause_next    = cause_q;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    regwrite      = 1'b0;
    memread       = 1'b0;
    memwrite      = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    reg2loc       = 1'b0;
    alusrc        = 1'b0;
    mem2reg       = 1'b0;
    aluop         = 4'b0000;
    signop        = 2'b00;
    trap          = 1'b0;
    trap_cause    = 2'b00;
    if (reset) begin
      state_next = S_FETCH;
      cause_next = 2'b00;
    end else begin
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
        reg2loc = f_reg2loc;
        alusrc  = f_alusrc;
        mem2reg = f_mem2reg;
        aluop   = f_aluop;
        signop  = f_signop;
      end
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write   = 1'b1;
            state_next = S_DECODE;
          end else if (timeout_hit) begin
            state_next = S_TRAP;
            cause_next = 2'b10;
          end
        end
        S_DECODE: begin
          if (cls_dec == C_NONE) begin
            state_next = S_TRAP;
            cause_next = 2'b01;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_B:          begin pc_write = 1'b1; uncond_branch = 1'b1; state_next = S_FETCH; end
            C_CBZ:        begin pc_write = 1'b1; branch = 1'b1; state_next = S_FETCH; end
            C_LDUR, C_STUR: state_next = S_MEM;
            default:      state_next = S_WB;
          endcase
        end
        S_MEM: begin
          memread  = (cls_q == C_LDUR);
          memwrite = (cls_q == C_STUR);
          if (dmem_ready) begin
            if (cls_q == C_STUR) begin
              pc_write   = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end else if (timeout_hit) begin
            state_next = S_TRAP;
            cause_next = 2'b10;
          end
        end
        S_WB: begin
          regwrite   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule
